// File: rtl/timer_pkg.sv
// Shared definitions for the down_timer block.
//   state_t      : FSM state encoding (IDLE, ARMED, RUN, DONE)
//   MODE_*       : reload-mode encoding captured alongside each load
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into count ticks: one tick every PRESCALE enabled cycles.
// The internal counter is held at zero whenever enable is low, so the first
// tick after enable rises lands in the PRESCALE-th enabled cycle.
//   clk    : system clock
//   rst    : asynchronous reset, active-low
//   enable : count permission (timer running and not being stopped)
//   tick   : high for the enabled cycle in which the counter reaches PRESCALE-1
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pcnt;

  assign tick = enable && (pcnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer. A start value is loaded over a
// valid/ready handshake, the timer is started, and it counts down to zero on
// prescaled ticks. The tick that sees zero raises a one-cycle tc pulse, after
// which the timer either stops in DONE (one-shot) or reloads (periodic).
//   clk        : system clock
//   rst        : asynchronous reset, active-low
//   load_valid : load request;  load_ready : load can be accepted (not RUN)
//   load_value : reload value;  load_mode  : 0 one-shot, 1 periodic
//   start      : start/resume (level);  stop : pause (level, wins over start)
//   count      : current count;  busy : in RUN;  tc : terminal-count pulse
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_t           st;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             tc_q;
  logic             enable;
  logic             tick;
  logic             load_acc;
  logic             go;

  assign load_ready = (st != RUN);
  assign busy       = (st == RUN);
  assign count      = cnt_q;
  assign tc         = tc_q;

  assign load_acc = load_valid && load_ready;
  assign go       = start && !stop;
  // A stop cycle disables the prescaler, which both clears it and swallows
  // any tick that would have landed in that cycle.
  assign enable   = (st == RUN) && !stop;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= tick && (cnt_q == '0);

      // load_ready is low in RUN, so this never competes with counting.
      if (load_acc) begin
        reload_q <= load_value;
        cnt_q    <= load_value;
        mode_q   <= load_mode;
      end

      case (st)
        IDLE: begin
          if (load_acc) st <= ARMED;
        end
        ARMED: begin
          // A load in the same cycle is captured above and run immediately.
          if (go) st <= RUN;
        end
        RUN: begin
          if (stop) begin
            st <= ARMED;
          end else if (tick) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (mode_q == MODE_PERIODIC) begin
              cnt_q <= reload_q;
            end else begin
              st <= DONE;
            end
          end
        end
        DONE: begin
          if (load_acc) begin
            st <= ARMED;
          end else if (go) begin
            st    <= RUN;
            cnt_q <= reload_q;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
